pipelined_alu: RTL
==================

# pipelined_alu

Parametrised, fully pipelined two-operand arithmetic/logic unit that generalises the single-function combinational binary primitives (add, sub, mult, logic, compare, shift) into one block. It has a runtime opcode, selectable signed/unsigned semantics and a configurable fixed latency. It accepts one operation per cycle, marked by `_go`, and presents the result exactly `LATENCY` cycles later with a matching valid strobe. Filament designs instantiate it wherever a statically scheduled, multi-cycle datapath operator is needed.

## Interface
- `WIDTH`, 32, operand and result width in bits (≥1)
- `LATENCY`, 2, cycles from `_go` to `out_valid` (≥1; elaboration error otherwise)
- `SIGNED`, 0, 1 selects two's-complement compares and arithmetic right shift

Clock and reset: one clock; reset is synchronous and active-high.
- `clk`  in  1  clock, rising edge
- `reset`  in  1  synchronous, active-high reset
- `_go`  in  1  operation valid this cycle
- `op`  in  4  opcode (`alu_op_t`)
- `left`  in  WIDTH  first operand
- `right`  in  WIDTH  second operand / shift amount
- `out`  out  WIDTH  result
- `out_valid`  out  1  `out` carries the result of the op issued `LATENCY` cycles earlier
- `illegal`  out  1  opcode of that op was undefined; qualified by `out_valid`

## Operation
- Opcodes: 0 ADD, 1 SUB, 2 MUL, 3 AND, 4 OR, 5 XOR, 6 SHL, 7 SHR, 8 LT, 9 EQ, 10 GT, 11 LTE, 12 GTE. Codes 13–15 are illegal.
- ADD, SUB and MUL: result is the low WIDTH bits; wrap-around, no saturation. Overflow is not flagged.
- Compares: 1-bit result, zero-extended to WIDTH. Signedness follows `SIGNED`. EQ is sign-agnostic.
- Shifts: amount is the full unsigned `right`.
  - Amount ≥ WIDTH gives 0, except arithmetic SHR of a negative value, which gives all ones.
  - SHR is logical when `SIGNED=0` and arithmetic when `SIGNED=1`.
- Illegal opcode: result 0, `illegal`=1.
- Combinational result is computed from the inputs in the `_go` cycle. It then enters a LATENCY-deep chain of (result, illegal, valid) registers.
- Each stage's data registers load only when the incoming valid is 1. Otherwise they hold.
  - So `out` and `illegal` hold the last delivered result between strobes.
  - The valid bit shifts every cycle.
- No backpressure; initiation interval 1. Inputs are don't-care when `_go`=0.

## Timing
- Reset values: `out`=0, `out_valid`=0, `illegal`=0. All stage registers, data and valid, clear to 0.
- Op issued with `_go`=1 at cycle t:
  - `out`, `illegal` and `out_valid`=1 appear at t+LATENCY.
  - `out_valid` is high for exactly one cycle per issued op.
- Back-to-back issues at t and t+1 produce results at t+L and t+L+1, in issue order, with no bubbles.
- `reset` asserted in cycle r:
  - Every in-flight op is discarded; no `out_valid` is produced for any op issued at or before r.
  - Outputs read 0 from r+1.
  - `_go` in the reset cycle is ignored.
  - An op issued at r+1 is accepted normally.
- `_go` and `reset` high together: reset wins.

## Structure
- Shared package `alu_pkg`:
  - `alu_op_t` (4-bit enum of the opcodes above)
  - `ALU_OP_LAST` constant (12) for illegal-range detection
- Sub-module `alu_core`: purely combinational, parameters WIDTH/SIGNED. Inputs op, left, right; outputs result, illegal.
- Top level instantiates one `alu_core` plus the generate-built LATENCY-stage register chain.

## Test plan
- WIDTH=8, LATENCY=3: ADD 200+100 with `_go` at t → `out`=44, `out_valid`=1 only at t+3. `out` holds 44 afterwards.
- Back-to-back MUL 15×17 at t, then SUB 3−5 at t+1 → `out`=255 at t+3, then 254 at t+4, then `out_valid` falls.
- Shifts:
  - SHL 1<<9 → 0.
  - SHR 0x80>>7 → 0x01 with SIGNED=0, 0xFF with SIGNED=1.
  - SHR 0x80>>200 with SIGNED=1 → 0xFF.
- Compares: LT 0x80 vs 0x01 → 0 with SIGNED=0, 1 with SIGNED=1. EQ 0x5A vs 0x5A → 1 in both modes.
- Opcode 14 with operands 7, 9 → `out`=0, `illegal`=1 with `out_valid`. Next legal op clears `illegal`.
- Issue ADD 1+1 at t, assert `reset` at t+1 → no `out_valid` at t+3, outputs 0. ADD issued at t+2 → `out`=2 at t+5.

Source files
------------

// File: rtl/alu_pkg.sv
// Shared opcode definitions for the pipelined ALU.
package alu_pkg;

  typedef enum logic [3:0] {
    OP_ADD = 4'd0,
    OP_SUB = 4'd1,
    OP_MUL = 4'd2,
    OP_AND = 4'd3,
    OP_OR  = 4'd4,
    OP_XOR = 4'd5,
    OP_SHL = 4'd6,
    OP_SHR = 4'd7,
    OP_LT  = 4'd8,
    OP_EQ  = 4'd9,
    OP_GT  = 4'd10,
    OP_LTE = 4'd11,
    OP_GTE = 4'd12
  } alu_op_t;

  // Highest defined opcode; anything above it is illegal.
  localparam int unsigned ALU_OP_LAST = 12;

endpackage

// File: rtl/alu_core.sv
// Combinational two-operand ALU: arithmetic, logic, shifts and compares.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH  = 32,
  parameter bit          SIGNED = 1'b0
) (
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] result,
  output logic             illegal
);

  logic             lt;
  logic             gt;
  logic             eq;
  logic [WIDTH-1:0] shr_res;

  // Magnitude compares and right shift follow the configured signedness.
  always_comb begin
    eq = (left == right);
    if (SIGNED) begin
      lt      = ($signed(left) < $signed(right));
      gt      = ($signed(left) > $signed(right));
      shr_res = $unsigned($signed(left) >>> right);
    end else begin
      lt      = (left < right);
      gt      = (left > right);
      shr_res = left >> right;
    end
  end

  // Opcode decode; undefined opcodes yield zero and raise illegal.
  always_comb begin
    result  = '0;
    illegal = (32'(op) > ALU_OP_LAST);
    case (op)
      OP_ADD:  result = left + right;
      OP_SUB:  result = left - right;
      OP_MUL:  result = left * right;
      OP_AND:  result = left & right;
      OP_OR:   result = left | right;
      OP_XOR:  result = left ^ right;
      OP_SHL:  result = left << right;
      OP_SHR:  result = shr_res;
      OP_LT:   result = WIDTH'(lt);
      OP_EQ:   result = WIDTH'(eq);
      OP_GT:   result = WIDTH'(gt);
      OP_LTE:  result = WIDTH'(lt | eq);
      OP_GTE:  result = WIDTH'(gt | eq);
      default: result = '0;
    endcase
  end

endmodule

// File: rtl/pipelined_alu.sv
// Fixed-latency pipelined ALU: one op per cycle, result LATENCY cycles later.
module pipelined_alu
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH   = 32,
  parameter int unsigned LATENCY = 2,
  parameter bit          SIGNED  = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             _go,
  input  logic [3:0]       op,
  input  logic [WIDTH-1:0] left,
  input  logic [WIDTH-1:0] right,
  output logic [WIDTH-1:0] out,
  output logic             out_valid,
  output logic             illegal
);

  if (LATENCY == 0) begin : g_bad_latency
    $error("pipelined_alu: LATENCY must be at least 1");
  end

  // Index 0 is the combinational core output; index i is stage i's register.
  logic [LATENCY:0][WIDTH-1:0] res_chain;
  logic [LATENCY:0]            ill_chain;
  logic [LATENCY:0]            vld_chain;

  logic [WIDTH-1:0] core_res;
  logic             core_ill;

  alu_core #(
    .WIDTH  (WIDTH),
    .SIGNED (SIGNED)
  ) u_core (
    .op      (op),
    .left    (left),
    .right   (right),
    .result  (core_res),
    .illegal (core_ill)
  );

  assign res_chain[0] = core_res;
  assign ill_chain[0] = core_ill;
  assign vld_chain[0] = _go;

  for (genvar i = 0; i < LATENCY; i++) begin : g_stage
    logic [WIDTH-1:0] res_q;
    logic             ill_q;
    logic             vld_q;

    // Valid shifts every cycle; data loads only behind a valid so it holds between strobes.
    always_ff @(posedge clk) begin
      if (reset) begin
        res_q <= '0;
        ill_q <= 1'b0;
        vld_q <= 1'b0;
      end else begin
        vld_q <= vld_chain[i];
        if (vld_chain[i]) begin
          res_q <= res_chain[i];
          ill_q <= ill_chain[i];
        end
      end
    end

    assign res_chain[i+1] = res_q;
    assign ill_chain[i+1] = ill_q;
    assign vld_chain[i+1] = vld_q;
  end

  assign out       = res_chain[LATENCY];
  assign illegal   = ill_chain[LATENCY];
  assign out_valid = vld_chain[LATENCY];

endmodule
